// File: rtl/master_fsm_if.sv
// Sequencer bus: layer-engine done pulses and PS write address in, broadcast state code out.
// The master modport is the sequencer; the slave modport is the datapath/PS side.
interface master_fsm_if #(
  parameter int STATE_DATAWIDTH   = 4,
  parameter int ADDRESS_DATAWIDTH = 13
);
  logic                         Conv_done;
  logic                         Avg_done;
  logic                         FC_done;
  logic                         Judge_done;
  logic [ADDRESS_DATAWIDTH-1:0] address;
  logic [STATE_DATAWIDTH-1:0]   state;

  modport master (
    input  Conv_done, Avg_done, FC_done, Judge_done, address,
    output state
  );

  modport slave (
    output Conv_done, Avg_done, FC_done, Judge_done, address,
    input  state
  );
endinterface

// File: rtl/master_fsm.sv
// Frame sequencer for the CNN accelerator: IDLE -> 3x(conv,conv,pool) -> FC -> JUDGE -> IDLE.
// New state visible one clock after the sampling edge; no backpressure, done inputs are level-sampled.
module master_fsm #(
  parameter int STATE_DATAWIDTH   = 4,
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int INPUT_SIZE        = 80
) (
  input  logic              clk,
  input  logic              reset,
  master_fsm_if.master      bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CONV1_1   = 4'd1,
    CONV1_2   = 4'd2,
    AVG_POOL1 = 4'd3,
    CONV2_1   = 4'd4,
    CONV2_2   = 4'd5,
    AVG_POOL2 = 4'd6,
    CONV3_1   = 4'd7,
    CONV3_2   = 4'd8,
    AVG_POOL3 = 4'd9,
    FC        = 4'd10,
    JUDGE     = 4'd11
  } state_t;

  localparam logic [ADDRESS_DATAWIDTH-1:0] LAST_ADDR =
    ADDRESS_DATAWIDTH'(INPUT_SIZE * INPUT_SIZE - 1);

  state_t state_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:      if (bus.address == LAST_ADDR) state_r <= CONV1_1;
        CONV1_1:   if (bus.Conv_done)  state_r <= CONV1_2;
        CONV1_2:   if (bus.Conv_done)  state_r <= AVG_POOL1;
        AVG_POOL1: if (bus.Avg_done)   state_r <= CONV2_1;
        CONV2_1:   if (bus.Conv_done)  state_r <= CONV2_2;
        CONV2_2:   if (bus.Conv_done)  state_r <= AVG_POOL2;
        AVG_POOL2: if (bus.Avg_done)   state_r <= CONV3_1;
        CONV3_1:   if (bus.Conv_done)  state_r <= CONV3_2;
        CONV3_2:   if (bus.Conv_done)  state_r <= AVG_POOL3;
        AVG_POOL3: if (bus.Avg_done)   state_r <= FC;
        FC:        if (bus.FC_done)    state_r <= JUDGE;
        JUDGE:     if (bus.Judge_done) state_r <= IDLE;
        // Unused codes 12-15 recover to IDLE.
        default:   state_r <= IDLE;
      endcase
    end
  end

  assign bus.state = STATE_DATAWIDTH'(state_r);

endmodule

// File: tb/tb_master_fsm.sv
// Directed stimulus for master_fsm; expected states queued at drive time, checked after each edge.
module tb_master_fsm;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  master_fsm_if #(.STATE_DATAWIDTH(4), .ADDRESS_DATAWIDTH(13)) bus ();

  master_fsm #(
    .STATE_DATAWIDTH  (4),
    .ADDRESS_DATAWIDTH(13),
    .INPUT_SIZE       (80)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the state expected after the edge, then check it.
  task automatic step(input logic rst, input logic [12:0] addr,
                      input logic cd, input logic ad, input logic fd, input logic jd,
                      input logic [3:0] exp_state, input string tag);
    logic [3:0] exp_v;
    string      tag_v;
    reset          = rst;
    bus.address    = addr;
    bus.Conv_done  = cd;
    bus.Avg_done   = ad;
    bus.FC_done    = fd;
    bus.Judge_done = jd;
    exp_q.push_back(exp_state);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    tag_v = tag_q.pop_front();
    tests++;
    assert (bus.state === exp_v) else begin
      fails++;
      $error("FAIL %s: state=%0d expected=%0d", tag_v, bus.state, exp_v);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset dominates a start address and every done.
    step(1, 13'd6399, 1, 1, 1, 1, 4'd0, "reset_all_high");
    step(0, 13'd1,    0, 0, 0, 0, 4'd0, "release_addr1");
    // Start condition.
    step(0, 13'd0,    0, 0, 0, 0, 4'd0, "addr0_idle");
    step(0, 13'd1,    0, 0, 0, 0, 4'd0, "addr1_idle");
    step(0, 13'd6399, 0, 0, 0, 0, 4'd1, "start_6399");
    step(0, 13'd1,    0, 0, 0, 0, 4'd1, "hold_conv1_1");
    // Irrelevant done ignored.
    step(0, 13'd1,    0, 1, 0, 0, 4'd1, "avg_in_conv1_1");
    step(0, 13'd1,    0, 0, 0, 0, 4'd1, "idle_gap_a");
    step(0, 13'd1,    1, 0, 0, 0, 4'd2, "conv1_1_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd2, "idle_gap_b");
    // All dones together: only Conv_done acts.
    step(0, 13'd1,    1, 1, 1, 1, 4'd3, "all_dones_conv1_2");
    step(0, 13'd1,    0, 0, 0, 0, 4'd3, "idle_gap_c");
    step(0, 13'd1,    1, 0, 0, 0, 4'd3, "conv_in_pool1");
    step(0, 13'd1,    0, 0, 0, 0, 4'd3, "idle_gap_d");
    step(0, 13'd1,    0, 1, 0, 0, 4'd4, "pool1_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd4, "idle_gap_e");
    step(0, 13'd1,    1, 0, 0, 0, 4'd5, "conv2_1_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd5, "idle_gap_f");
    step(0, 13'd1,    1, 0, 0, 0, 4'd6, "conv2_2_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd6, "idle_gap_g");
    step(0, 13'd1,    0, 1, 0, 0, 4'd7, "pool2_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd7, "idle_gap_h");
    step(0, 13'd1,    1, 0, 0, 0, 4'd8, "conv3_1_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd8, "idle_gap_i");
    step(0, 13'd1,    1, 0, 0, 0, 4'd9, "conv3_2_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd9, "idle_gap_j");
    step(0, 13'd1,    0, 0, 1, 0, 4'd9, "fc_in_pool3");
    step(0, 13'd1,    0, 1, 0, 0, 4'd10, "pool3_done");
    step(0, 13'd1,    0, 0, 0, 1, 4'd10, "judge_in_fc");
    step(0, 13'd1,    0, 0, 1, 0, 4'd11, "fc_done");
    step(0, 13'd1,    0, 0, 0, 0, 4'd11, "idle_gap_k");
    step(0, 13'd1,    0, 0, 0, 1, 4'd0, "judge_done");
    step(0, 13'd1,    0, 0, 1, 0, 4'd0, "fc_in_idle");
    step(0, 13'd1,    1, 0, 0, 0, 4'd0, "conv_in_idle");
    // Second frame.
    step(0, 13'd6399, 0, 0, 0, 0, 4'd1, "restart_6399");
    // A held done advances one state per edge.
    step(0, 13'd1,    1, 0, 0, 0, 4'd2, "held_conv_edge1");
    step(0, 13'd1,    1, 0, 0, 0, 4'd3, "held_conv_edge2");
    step(0, 13'd1,    0, 1, 0, 0, 4'd4, "pool1_done_f2");
    step(0, 13'd1,    1, 0, 0, 0, 4'd5, "conv2_1_done_f2");
    step(0, 13'd6399, 0, 0, 0, 0, 4'd5, "addr6399_in_conv2_2");
    step(0, 13'd1,    1, 0, 0, 0, 4'd6, "conv2_2_done_f2");
    step(0, 13'd1,    0, 1, 0, 0, 4'd7, "pool2_done_f2");
    // Mid-operation reset.
    step(1, 13'd1,    0, 0, 0, 0, 4'd0, "reset_in_conv3_1");
    step(0, 13'd1,    0, 0, 0, 0, 4'd0, "after_reset_idle");
    step(0, 13'd1,    1, 1, 1, 1, 4'd0, "dones_after_reset");
    step(0, 13'd6398, 0, 0, 0, 0, 4'd0, "addr6398_no_start");
    step(0, 13'd6399, 0, 0, 0, 0, 4'd1, "start_after_reset");
    // Run a frame to JUDGE with address left at 6399: immediate restart.
    step(0, 13'd6399, 1, 0, 0, 0, 4'd2, "f3_c11");
    step(0, 13'd6399, 1, 0, 0, 0, 4'd3, "f3_c12");
    step(0, 13'd6399, 0, 1, 0, 0, 4'd4, "f3_p1");
    step(0, 13'd6399, 1, 0, 0, 0, 4'd5, "f3_c21");
    step(0, 13'd6399, 1, 0, 0, 0, 4'd6, "f3_c22");
    step(0, 13'd6399, 0, 1, 0, 0, 4'd7, "f3_p2");
    step(0, 13'd6399, 1, 0, 0, 0, 4'd8, "f3_c31");
    step(0, 13'd6399, 1, 0, 0, 0, 4'd9, "f3_c32");
    step(0, 13'd6399, 0, 1, 0, 0, 4'd10, "f3_p3");
    step(0, 13'd6399, 0, 0, 1, 0, 4'd11, "f3_fc");
    step(0, 13'd6399, 0, 0, 0, 1, 4'd0, "f3_judge");
    step(0, 13'd6399, 0, 0, 0, 0, 4'd1, "f3_immediate_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
